// File: rtl/pe_stream_issuer_if.sv
// Stream and PE-lane bundle for pe_stream_issuer.
// master = issuer side (drives readies, PE lane inputs and the result stream),
// slave  = environment side (operand sources, PE array, result sink).
interface pe_stream_issuer_if #(
  parameter int PHIT_SIZE = 512
);
  logic [PHIT_SIZE-1:0] s_a_tdata;
  logic                 s_a_tvalid;
  logic                 s_a_tready;
  logic [PHIT_SIZE-1:0] s_b_tdata;
  logic                 s_b_tvalid;
  logic                 s_b_tready;
  logic [PHIT_SIZE-1:0] pe_inp1;
  logic [PHIT_SIZE-1:0] pe_inp2;
  logic [1:0]           pe_op;
  logic [PHIT_SIZE-1:0] pe_out1;
  logic [PHIT_SIZE-1:0] m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic                 m_tlast;

  modport master (
    input  s_a_tdata, s_a_tvalid, s_b_tdata, s_b_tvalid, pe_out1, m_tready,
    output s_a_tready, s_b_tready, pe_inp1, pe_inp2, pe_op, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output s_a_tdata, s_a_tvalid, s_b_tdata, s_b_tvalid, pe_out1, m_tready,
    input  s_a_tready, s_b_tready, pe_inp1, pe_inp2, pe_op, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/pe_stream_issuer.sv
// pe_stream_issuer: feeds A/B operand phits into a fixed-latency PE lane array,
// captures lane results LATENCY cycles after presentation and streams them out
// through a credit-protected result FIFO.
// Optional: define ISSUER_STALL_CNT_EN to add the stall_cnt output.
module pe_stream_issuer #(
  parameter int DWIDTH      = 64,
  parameter int SIMD_DEGREE = 8,
  parameter int PHIT_SIZE   = 512,
  parameter int LATENCY     = 6,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEN_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cfg_op,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
`ifdef ISSUER_STALL_CNT_EN
  output logic [LEN_W-1:0] stall_cnt,
`endif
  pe_stream_issuer_if.master io
);

  if (PHIT_SIZE != DWIDTH * SIMD_DEGREE) begin : g_bad_phit
    $error("PHIT_SIZE must equal DWIDTH*SIMD_DEGREE");
  end

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state, state_n;
  logic [1:0]          op_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issued;
  logic [LEN_W-1:0]    popped;
  logic [LATENCY:0]    vld_sr;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       credits;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [PHIT_SIZE-1:0] mem [FIFO_DEPTH];
  logic                start_acc;
  logic                both_valid;
  logic                fire;
  logic                push, pop;

  assign start_acc  = (state == IDLE) && start;
  assign both_valid = io.s_a_tvalid && io.s_b_tvalid;

  // Results currently owed to the FIFO: issue stage plus every PE pipeline stage
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= LATENCY; i++) begin
      inflight = inflight + CW'(vld_sr[i]);
    end
  end

  assign credits = CW'(FIFO_DEPTH) - fifo_count - inflight;
  assign fire    = (state == RUN) && both_valid && (issued < len_q) && (credits != '0);

  assign io.s_a_tready = fire;
  assign io.s_b_tready = fire;

  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == FIN);
  assign io.pe_op = busy ? op_q : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (cfg_len == '0) ? FIN : RUN;
      RUN:     if (issued == len_q) state_n = DRAIN;
      DRAIN:   if (popped == len_q) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Job configuration and progress counters
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      len_q  <= '0;
      issued <= '0;
      popped <= '0;
    end else if (start_acc) begin
      op_q   <= cfg_op;
      len_q  <= cfg_len;
      issued <= '0;
      popped <= '0;
    end else begin
      if (fire) issued <= issued + LEN_W'(1);
      if (pop)  popped <= popped + LEN_W'(1);
    end
  end

  // Lane i of each phit occupies the same bit slice on input and PE buses, so
  // unpacking to lanes is a straight copy; idle cycles present zeros
  always_ff @(posedge clk) begin
    if (rst || !fire) begin
      io.pe_inp1 <= '0;
      io.pe_inp2 <= '0;
    end else begin
      io.pe_inp1 <= io.s_a_tdata;
      io.pe_inp2 <= io.s_b_tdata;
    end
  end

  // Issue tracker: bit k set means a phit was issued k+1 edges ago
  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[LATENCY-1:0], fire};
  end

  assign push        = vld_sr[LATENCY];
  assign io.m_tvalid = (fifo_count != '0);
  assign pop         = io.m_tvalid && io.m_tready;
  assign io.m_tdata  = mem[rd_ptr];
  assign io.m_tlast  = io.m_tvalid && (popped == len_q - LEN_W'(1));

  // Result storage (no reset needed; occupancy tracked by fifo_count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io.pe_out1;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef ISSUER_STALL_CNT_EN
  // Cycles where an issue was possible except for lack of credit, saturating
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && both_valid && (issued < len_q) &&
                 (credits == '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + LEN_W'(1);
    end
  end
`endif

endmodule
